usb_rx_pkt_ctrl: RTL
====================

# usb_rx_pkt_ctrl

Parametrised receive control unit for the USB full-speed receiver. It sits between the bit-level receive datapath (edge detector, EOP detector, shift-enable timer, byte shift register) and the receive FIFO. It validates the SYNC byte, optionally checks the PID, enforces a maximum packet length, issues one FIFO write per accepted byte, counts bytes, and reports packet completion or error. It succeeds the fixed-function RCU and adds a programmable SYNC pattern, a length limit, a byte count output and a packet-done strobe.

## Interface
- SYNC_BYTE, 8'h80 — byte value required as the first received byte.
- MAX_BYTES, 64 — maximum number of data bytes (PID included) per packet; range 1..255.
- CNT_W, $clog2(MAX_BYTES+1) — width of byte_count; derived, not overridden.

- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- d_edge  in  1  line transition detected; starts a packet.
- eop  in  1  SE0 present on the bus.
- shift_enable  in  1  one-cycle bit-sample strobe.
- byte_received  in  1  one-cycle strobe; rcv_data holds a complete byte.
- rcv_data  in  8  last received byte, LSB-first reassembled.
- rcving  out  1  packet reception in progress.
- w_enable  out  1  one-cycle FIFO write strobe for rcv_data.
- r_error  out  1  packet error flag; sticky until the next packet starts.
- pkt_done  out  1  one-cycle strobe on clean packet completion.
- byte_count  out  CNT_W  data bytes written for the current or last packet.

## Operation
- States: IDLE, SYNC_WAIT, SYNC_CHECK, DATA, STORE, BYTE_END, EOP_WAIT, DONE, ERR, ERR_EOP, ERR_IDLE.
- IDLE: d_edge -> SYNC_WAIT.
- SYNC_WAIT: byte_received -> SYNC_CHECK; else eop&shift_enable -> ERR_EOP.
- SYNC_CHECK lasts one cycle: rcv_data==SYNC_BYTE -> DATA; otherwise -> ERR.
- DATA: byte_received -> STORE; else eop&shift_enable -> ERR_EOP (partial byte or empty packet).
- STORE lasts one cycle and performs the accept check:
  - If byte_count==MAX_BYTES (overflow) -> ERR, with no write.
  - If the PID check fails (see Configuration) -> ERR, with no write.
  - Otherwise w_enable=1, byte_count+1, -> BYTE_END.
- BYTE_END: on shift_enable, eop -> EOP_WAIT and ~eop -> DATA.
- EOP_WAIT: eop&shift_enable (second SE0 bit) -> DONE.
- DONE: shift_enable -> IDLE. pkt_done=1 in the cycle DONE&shift_enable.
- ERR: eop&shift_enable -> ERR_EOP.
- ERR_EOP: shift_enable -> ERR_IDLE.
- ERR_IDLE: d_edge -> SYNC_WAIT.
- rcving: 0 in IDLE and ERR_IDLE, 1 in all other states.
- r_error: 1 in ERR, ERR_EOP and ERR_IDLE, 0 elsewhere.
- byte_count clears to 0 on every entry to SYNC_WAIT. It holds its value through DONE, IDLE and the error states. It never exceeds MAX_BYTES.
- Simultaneous byte_received and eop in DATA: byte_received wins.
- d_edge is ignored outside IDLE and ERR_IDLE.

## Timing
- Reset (rst=1, async) forces state IDLE. rcving, w_enable, r_error, pkt_done and byte_count are all 0. Asserting rst mid-packet aborts with no further writes.
- Outputs are decoded from the registered state (Moore). The exceptions are w_enable, which is gated by the STORE accept check, and pkt_done, which is gated by shift_enable.
- byte_received at cycle N gives STORE at N+1, so w_enable=1 at N+1. byte_count shows the incremented value at N+2.
- Bad SYNC: byte_received at N, then SYNC_CHECK at N+1, then r_error=1 at N+2.
- pkt_done and w_enable are each high for exactly one clk cycle per event.

## Configuration
- RCU_PID_CHECK_EN defined: in STORE with byte_count==0, the byte is accepted only when rcv_data[7:4] == ~rcv_data[3:0]. On mismatch -> ERR, with no write.
- RCU_PID_CHECK_EN undefined: the first byte is treated as any other data byte. Only the SYNC and length checks apply.

## Test plan
- Good packet: SYNC 0x80, then 0xC3, 0x11, 0x22, then 2 SE0 bits -> three w_enable pulses each 1 cycle after byte_received; byte_count=3; one pkt_done pulse; r_error=0 throughout.
- Bad SYNC 0x81 -> r_error=1 two cycles after byte_received; no w_enable; r_error held through EOP and ERR_IDLE; next d_edge clears r_error and byte_count=0.
- Overflow with MAX_BYTES=4: SYNC plus 5 bytes -> exactly 4 w_enable pulses; r_error=1 on the 5th; byte_count=4; no pkt_done.
- PID 0xC4 as first byte -> with RCU_PID_CHECK_EN: r_error=1 and 0 writes. Without it: written, and byte_count=1 after that byte.
- EOP mid-byte: SYNC, 0xC3, then 3 bits then SE0 -> 1 write, then ERR_EOP; r_error=1; rcving=0 after the next shift_enable.
- Reset mid-packet: rst asserted during DATA after 2 bytes -> all outputs 0 immediately; the next packet is processed normally from IDLE.

Source files
------------

// File: rtl/usb_rx_pkt_ctrl.sv
// usb_rx_pkt_ctrl - USB FS receive packet control: SYNC check, optional PID check (RCU_PID_CHECK_EN),
// length limit, FIFO write strobe, byte count, done/error reporting. Rev 1.0
`default_nettype none

module usb_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64,
  localparam int        CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             byte_received,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic             pkt_done,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SYNC_WAIT  = 4'd1,
    SYNC_CHECK = 4'd2,
    DATA       = 4'd3,
    STORE      = 4'd4,
    BYTE_END   = 4'd5,
    EOP_WAIT   = 4'd6,
    DONE       = 4'd7,
    ERR        = 4'd8,
    ERR_EOP    = 4'd9,
    ERR_IDLE   = 4'd10
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  state_t           state, next_state;
  logic [CNT_W-1:0] count;
  logic             cnt_clr, cnt_inc, pid_ok, accept;

`ifdef RCU_PID_CHECK_EN
  // Only the first data byte is a PID; it must carry its own complement.
  assign pid_ok = (count != '0) || (rcv_data[7:4] == ~rcv_data[3:0]);
`else
  assign pid_ok = 1'b1;
`endif

  assign accept = (count != MAX_CNT) && pid_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (cnt_clr)
        count <= '0;
      else if (cnt_inc)
        count <= count + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    w_enable   = 1'b0;
    pkt_done   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE, ERR_IDLE: begin
        if (d_edge) begin
          next_state = SYNC_WAIT;
          cnt_clr    = 1'b1;
        end
      end
      SYNC_WAIT: begin
        if (byte_received)
          next_state = SYNC_CHECK;
        else if (eop && shift_enable)
          next_state = ERR_EOP;
      end
      SYNC_CHECK: next_state = (rcv_data == SYNC_BYTE) ? DATA : ERR;
      DATA: begin
        // A completed byte takes priority over a coincident SE0.
        if (byte_received)
          next_state = STORE;
        else if (eop && shift_enable)
          next_state = ERR_EOP;
      end
      STORE: begin
        if (accept) begin
          w_enable   = 1'b1;
          cnt_inc    = 1'b1;
          next_state = BYTE_END;
        end else begin
          next_state = ERR;
        end
      end
      BYTE_END: begin
        if (shift_enable)
          next_state = eop ? EOP_WAIT : DATA;
      end
      EOP_WAIT: begin
        if (eop && shift_enable)
          next_state = DONE;
      end
      DONE: begin
        if (shift_enable) begin
          pkt_done   = 1'b1;
          next_state = IDLE;
        end
      end
      ERR: begin
        if (eop && shift_enable)
          next_state = ERR_EOP;
      end
      ERR_EOP: begin
        if (shift_enable)
          next_state = ERR_IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign rcving     = (state != IDLE) && (state != ERR_IDLE);
  assign r_error    = (state == ERR) || (state == ERR_EOP) || (state == ERR_IDLE);
  assign byte_count = count;

endmodule

`default_nettype wire
